// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and widths for the two-master bus arbiter
package bus_pkg;

    localparam int BUS_AW = 32;
    localparam int BUS_DW = 32;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } tsize_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWNED = 2'd1,
        XFER  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/bus_watchdog.sv
// rtl/bus_watchdog.sv - XFER timeout counter, built only with ARB_WATCHDOG_EN
`ifdef ARB_WATCHDOG_EN
module bus_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_xfer,
    output logic timeout
);

    // Count is 0 in the first XFER cycle, so the limit is one less than the cycle budget.
    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!in_xfer) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    assign timeout = in_xfer && (cnt == LIMIT);

endmodule
`endif

// File: rtl/bus_arbiter_2m.sv
// rtl/bus_arbiter_2m.sv - round-robin two-master bus arbiter; optional watchdog via ARB_WATCHDOG_EN
import bus_pkg::*;

module bus_arbiter_2m #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                m0_breq,
    input  logic                m1_breq,
    output logic                m0_bgnt,
    output logic                m1_bgnt,
    input  logic                m0_bstart,
    input  logic                m1_bstart,
    input  logic [BUS_AW-1:0]   m0_addr,
    input  logic [BUS_AW-1:0]   m1_addr,
    input  logic [BUS_DW-1:0]   m0_wdata,
    input  logic [BUS_DW-1:0]   m1_wdata,
    input  logic [1:0]          m0_tsize,
    input  logic [1:0]          m1_tsize,
    output logic [BUS_DW-1:0]   m0_rdata,
    output logic [BUS_DW-1:0]   m1_rdata,
    output logic                m0_bdone,
    output logic                m1_bdone,
    output logic                m0_berror,
    output logic                m1_berror,
    output logic                s_bstart,
    output logic [BUS_AW-1:0]   s_addr,
    output logic [BUS_DW-1:0]   s_wdata,
    output logic [1:0]          s_tsize,
    input  logic [BUS_DW-1:0]   s_rdata,
    input  logic                s_bdone
);

    arb_state_t state, state_nxt;
    logic owner, owner_nxt;
    logic last, last_nxt;
    logic own_req, oth_req, own_start;
    logic owned, in_xfer, timeout, xfer_end;

    assign own_req   = owner ? m1_breq   : m0_breq;
    assign oth_req   = owner ? m0_breq   : m1_breq;
    assign own_start = owner ? m1_bstart : m0_bstart;
    assign owned     = (state != IDLE);
    assign in_xfer   = (state == XFER);

`ifdef ARB_WATCHDOG_EN
    bus_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_xfer (in_xfer),
        .timeout (timeout)
    );
`else
    // A zero budget is outside the legal range, so this is constant 0: XFER waits for s_bdone.
    assign timeout = (TIMEOUT_CYCLES == 0) && in_xfer;
`endif

    assign xfer_end = s_bdone || timeout;

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (m0_breq || m1_breq) begin
                    state_nxt = OWNED;
                    owner_nxt = (m0_breq && m1_breq) ? ~last : m1_breq;
                    last_nxt  = owner_nxt;
                end
            end
            OWNED: begin
                // A forwarded start must be tracked to completion even if breq drops with it.
                if (own_start) begin
                    state_nxt = XFER;
                end else if (!own_req) begin
                    state_nxt = IDLE;
                end
            end
            XFER: begin
                if (xfer_end) begin
                    state_nxt = (own_req && !oth_req) ? OWNED : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            last  <= last_nxt;
        end
    end

    assign m0_bgnt = owned && !owner;
    assign m1_bgnt = owned &&  owner;

    assign s_bstart = (state == OWNED) && own_start;
    assign s_addr   = !owned ? '0 : (owner ? m1_addr  : m0_addr);
    assign s_wdata  = !owned ? '0 : (owner ? m1_wdata : m0_wdata);
    assign s_tsize  = !owned ? '0 : (owner ? m1_tsize : m0_tsize);

    assign m0_rdata  = (in_xfer && !owner) ? s_rdata : '0;
    assign m1_rdata  = (in_xfer &&  owner) ? s_rdata : '0;
    assign m0_bdone  = in_xfer && !owner && s_bdone;
    assign m1_bdone  = in_xfer &&  owner && s_bdone;
    assign m0_berror = in_xfer && !owner && timeout && !s_bdone;
    assign m1_berror = in_xfer &&  owner && timeout && !s_bdone;

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// tb/tb_bus_arbiter_2m.sv - directed and random checks of bus_arbiter_2m against a behavioural model
module tb_bus_arbiter_2m;

    localparam int TMO = 4;
`ifdef ARB_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        br [2];
    logic        bs [2];
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    logic [1:0]  ts [2];
    logic [31:0] s_rdata;
    logic        s_bdone;

    logic        m0_bgnt, m1_bgnt, m0_bdone, m1_bdone, m0_berror, m1_berror, s_bstart;
    logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
    logic [1:0]  s_tsize;

    logic        gnt_o [2];
    logic        done_o [2];
    logic        err_o [2];
    logic [31:0] rd_o [2];

    assign gnt_o[0]  = m0_bgnt;   assign gnt_o[1]  = m1_bgnt;
    assign done_o[0] = m0_bdone;  assign done_o[1] = m1_bdone;
    assign err_o[0]  = m0_berror; assign err_o[1]  = m1_berror;
    assign rd_o[0]   = m0_rdata;  assign rd_o[1]   = m1_rdata;

    always #5 clk = ~clk;

    bus_arbiter_2m #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_breq(br[0]), .m1_breq(br[1]),
        .m0_bgnt(m0_bgnt), .m1_bgnt(m1_bgnt),
        .m0_bstart(bs[0]), .m1_bstart(bs[1]),
        .m0_addr(ad[0]), .m1_addr(ad[1]),
        .m0_wdata(wd[0]), .m1_wdata(wd[1]),
        .m0_tsize(ts[0]), .m1_tsize(ts[1]),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .m0_bdone(m0_bdone), .m1_bdone(m1_bdone),
        .m0_berror(m0_berror), .m1_berror(m1_berror),
        .s_bstart(s_bstart), .s_addr(s_addr), .s_wdata(s_wdata), .s_tsize(s_tsize),
        .s_rdata(s_rdata), .s_bdone(s_bdone)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model: own = -1 when nobody holds the bus; busy = a transaction is outstanding.
    int own;
    int last_g;
    bit busy;
    int xc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic bit model_timeout();
        return WD_EN && busy && (xc + 1 == TMO);
    endfunction

    task automatic model_reset();
        own = -1; last_g = 1; busy = 1'b0; xc = 0;
    endtask

    task automatic model_step();
        bit tmo;
        tmo = model_timeout();
        if (own < 0) begin
            if (br[0] && br[1]) own = 1 - last_g;
            else if (br[0])     own = 0;
            else if (br[1])     own = 1;
            if (own >= 0) last_g = own;
            busy = 1'b0;
        end else if (!busy) begin
            if (bs[own]) begin
                busy = 1'b1;
                xc = 0;
            end else if (!br[own]) begin
                own = -1;
            end
        end else if (s_bdone || tmo) begin
            busy = 1'b0;
            if (!br[own] || br[1 - own]) own = -1;
        end else begin
            xc++;
        end
    endtask

    task automatic check_model();
        logic [31:0] e_addr, e_wdata;
        logic [1:0]  e_ts;
        logic        e_st, tmo;
        tmo = model_timeout();
        if (own >= 0) begin
            e_addr = ad[own]; e_wdata = wd[own]; e_ts = ts[own];
            e_st = bs[own] && !busy;
        end else begin
            e_addr = '0; e_wdata = '0; e_ts = '0; e_st = 1'b0;
        end
        chk1("s_bstart", s_bstart, e_st);
        chk("s_addr", s_addr, e_addr);
        chk("s_wdata", s_wdata, e_wdata);
        chk("s_tsize", {30'd0, s_tsize}, {30'd0, e_ts});
        for (int i = 0; i < 2; i++) begin
            chk1($sformatf("m%0d_bgnt", i), gnt_o[i], own == i);
            chk($sformatf("m%0d_rdata", i), rd_o[i], (own == i && busy) ? s_rdata : 32'd0);
            chk1($sformatf("m%0d_bdone", i), done_o[i], own == i && busy && s_bdone);
            chk1($sformatf("m%0d_berror", i), err_o[i], own == i && busy && tmo && !s_bdone);
        end
    endtask

    task automatic eval();
        #1;
        check_model();
    endtask

    task automatic adv();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < 2; i++) begin
            br[i] = 1'b0; bs[i] = 1'b0;
            ad[i] = $urandom; wd[i] = $urandom; ts[i] = 2'($urandom_range(0, 2));
        end
        s_rdata = $urandom;
        s_bdone = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        #1;
        check_model();
        chk1("reset_m0_bgnt", m0_bgnt, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // single master read
        br[0] = 1'b1;
        eval(); adv();
        bs[0] = 1'b1; ad[0] = 32'hF000_0000;
        eval();
        chk1("t1_m0_bgnt", m0_bgnt, 1'b1);
        chk1("t1_s_bstart", s_bstart, 1'b1);
        chk("t1_s_addr", s_addr, 32'hF000_0000);
        adv();
        bs[0] = 1'b0;
        eval(); adv();
        s_bdone = 1'b1; s_rdata = 32'hDEAD_BEEF;
        eval();
        chk("t1_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk1("t1_m0_bdone", m0_bdone, 1'b1);
        adv();
        s_bdone = 1'b0; br[0] = 1'b0;
        eval();
        chk1("t1_hold_gnt", m0_bgnt, 1'b1);
        adv();
        eval();
        chk1("t1_release", m0_bgnt, 1'b0);
        adv();

        // tie after reset, forced release and hand-over
        rst_n = 1'b0; model_reset(); #1; check_model();
        @(negedge clk); rst_n = 1'b1;
        br[0] = 1'b1; br[1] = 1'b1;
        eval(); adv();
        bs[0] = 1'b1;
        eval();
        chk1("t2_m0_first", m0_bgnt, 1'b1);
        chk1("t2_m1_wait", m1_bgnt, 1'b0);
        adv();
        bs[0] = 1'b0; s_bdone = 1'b1;
        eval();
        chk1("t2_m0_bdone", m0_bdone, 1'b1);
        adv();
        s_bdone = 1'b0;
        eval();
        chk1("t2_gap_m0", m0_bgnt, 1'b0);
        chk1("t2_gap_m1", m1_bgnt, 1'b0);
        adv();

        // non-owner start is not forwarded
        bs[0] = 1'b1; ad[0] = 32'hF000_0010; ad[1] = 32'h1000_0040;
        eval();
        chk1("t3_m1_bgnt", m1_bgnt, 1'b1);
        chk1("t3_no_fwd", s_bstart, 1'b0);
        chk("t3_owner_addr", s_addr, 32'h1000_0040);
        adv();
        bs[0] = 1'b0; bs[1] = 1'b1;
        eval();
        chk1("t3_m1_start", s_bstart, 1'b1);
        adv();
        bs[1] = 1'b0;
        repeat (2) begin
            s_rdata = $urandom | 32'd1;
            eval();
            chk1("t3_m0_wait", m0_bgnt, 1'b0);
            chk("t3_m0_rdata0", m0_rdata, 32'd0);
            adv();
        end
        s_bdone = 1'b1; s_rdata = 32'hCAFE_F00D;
        eval();
        chk1("t3_m1_bdone", m1_bdone, 1'b1);
        chk("t3_m1_rdata", m1_rdata, 32'hCAFE_F00D);
        chk1("t3_m0_bdone0", m0_bdone, 1'b0);
        adv();
        s_bdone = 1'b0;
        eval();
        chk1("t3_gap", m0_bgnt, 1'b0);
        adv();
        eval();
        chk1("t3_m0_gnt", m0_bgnt, 1'b1);

        // watchdog timeout (or indefinite wait without it), then a late s_bdone
        br[1] = 1'b0; bs[0] = 1'b1;
        eval(); adv();
        bs[0] = 1'b0;
        for (int k = 1; k <= TMO; k++) begin
            eval();
            if (k == TMO) chk1("wd_berror", m0_berror, WD_EN);
            adv();
        end
        s_bdone = 1'b1;
        eval();
        chk1("wd_late_bdone", m0_bdone, !WD_EN);
        adv();
        s_bdone = 1'b0;

        // reset in the middle of a transaction
        bs[0] = 1'b1;
        eval(); adv();
        bs[0] = 1'b0; s_bdone = 1'b1;
        eval();
        #2 rst_n = 1'b0;
        #1;
        chk1("rst_m0_bgnt", m0_bgnt, 1'b0);
        chk1("rst_m1_bgnt", m1_bgnt, 1'b0);
        chk1("rst_s_bstart", s_bstart, 1'b0);
        chk1("rst_m0_bdone", m0_bdone, 1'b0);
        chk("rst_s_addr", s_addr, 32'd0);
        model_reset();
        check_model();
        @(negedge clk);
        rst_n = 1'b1; s_bdone = 1'b0;
        eval();
        chk1("rst_regrant_lat", m0_bgnt, 1'b0);
        adv();
        eval();
        chk1("rst_regrant", m0_bgnt, 1'b1);
        adv();

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                br[i] = ($urandom_range(0, 3) != 0);
                bs[i] = ($urandom_range(0, 2) == 0);
                ad[i] = $urandom; wd[i] = $urandom; ts[i] = 2'($urandom_range(0, 2));
            end
            s_rdata = $urandom;
            s_bdone = ($urandom_range(0, 2) == 0);
            eval(); adv();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
